// File: rtl/ir_transmit.sv
// NEC infrared transmitter: serialises a 32-bit frame {~cmd, cmd, addr}
// LSB first as pulse-distance marks/spaces. It drives both the
// demodulated envelope (oIRDA) and a carrier-modulated LED output.
// A qualified start can instead send the short NEC repeat code.
module ir_transmit #(
  parameter int LEAD_MARK_CYC    = 450000,
  parameter int LEAD_SPACE_CYC   = 225000,
  parameter int REP_SPACE_CYC    = 112500,
  parameter int BIT_MARK_CYC     = 28000,
  parameter int ZERO_SPACE_CYC   = 28000,
  parameter int ONE_SPACE_CYC    = 84500,
  parameter int GAP_CYC          = 2000000,
  parameter int CARRIER_HALF_CYC = 658
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic        iREPEAT,
  input  logic [15:0] iADDR,
  input  logic [7:0]  iCMD,
  output logic        oIRDA,
  output logic        oIR_CARRIER,
  output logic        oBUSY,
  output logic        oDONE
);

  // 22 bits comfortably holds the 2,000,000-cycle gap without wrapping.
  localparam int CNT_W = 22;
  localparam int CAR_W = 16;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE,
    BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] dur_tgt;
  logic             dur_last;
  logic [4:0]       bit_idx;
  logic [31:0]      frame;
  logic             rep;
  logic [CAR_W-1:0] car_cnt;
  logic             car_phase;
  logic             accept;
  logic             state_chg;

  assign accept    = (state == IDLE) && iSTART;
  assign state_chg = (state_nxt != state);
  assign dur_last  = (dur_cnt == dur_tgt - CNT_W'(1));

  // Length of the current state in clock cycles; bit spaces depend on the bit value.
  always_comb begin
    dur_tgt = CNT_W'(1);
    case (state)
      LEAD_MARK:  dur_tgt = CNT_W'(LEAD_MARK_CYC);
      LEAD_SPACE: dur_tgt = CNT_W'(LEAD_SPACE_CYC);
      REP_SPACE:  dur_tgt = CNT_W'(REP_SPACE_CYC);
      BIT_MARK:   dur_tgt = CNT_W'(BIT_MARK_CYC);
      BIT_SPACE:  dur_tgt = frame[bit_idx] ? CNT_W'(ONE_SPACE_CYC) : CNT_W'(ZERO_SPACE_CYC);
      STOP_MARK:  dur_tgt = CNT_W'(BIT_MARK_CYC);
      GAP:        dur_tgt = CNT_W'(GAP_CYC);
      default:    dur_tgt = CNT_W'(1);
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: each timed state advances on its last cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (iSTART)   state_nxt = LEAD_MARK;
      LEAD_MARK:  if (dur_last) state_nxt = rep ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (dur_last) state_nxt = BIT_MARK;
      REP_SPACE:  if (dur_last) state_nxt = STOP_MARK;
      BIT_MARK:   if (dur_last) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (dur_last) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (dur_last) state_nxt = GAP;
      GAP:        if (dur_last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Frame latch, duration/bit counters and carrier phase; counters restart on every state change.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      frame     <= '0;
      rep       <= 1'b0;
      bit_idx   <= '0;
      dur_cnt   <= '0;
      car_cnt   <= '0;
      car_phase <= 1'b0;
    end else begin
      if (accept) begin
        frame   <= {~iCMD, iCMD, iADDR};
        rep     <= iREPEAT;
        bit_idx <= '0;
      end else if (state == BIT_SPACE && dur_last) begin
        bit_idx <= bit_idx + 5'd1;
      end

      if (state_chg || state == IDLE) dur_cnt <= '0;
      else                            dur_cnt <= dur_cnt + CNT_W'(1);

      if (state_chg) begin
        car_cnt   <= '0;
        car_phase <= 1'b1;
      end else if (car_cnt == CAR_W'(CARRIER_HALF_CYC - 1)) begin
        car_cnt   <= '0;
        car_phase <= ~car_phase;
      end else begin
        car_cnt   <= car_cnt + CAR_W'(1);
      end
    end
  end

  // Outputs decode the registered state: envelope low and carrier gated on during marks.
  always_comb begin
    oIRDA       = 1'b1;
    oIR_CARRIER = 1'b0;
    oBUSY       = (state != IDLE);
    oDONE       = 1'b0;
    case (state)
      LEAD_MARK, BIT_MARK, STOP_MARK: begin
        oIRDA       = 1'b0;
        oIR_CARRIER = car_phase;
      end
      GAP:     oDONE = dur_last;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ir_transmit.sv
// Bench for ir_transmit with shortened timing parameters. A segment-level
// model expands each accepted request into the per-cycle outputs it must
// produce; a compare process checks every cycle. Monitors decode the
// envelope back into a frame word and measure busy length / done pulses.
module tb_ir_transmit;

  localparam int LM = 40;
  localparam int LS = 20;
  localparam int RS = 10;
  localparam int BM = 4;
  localparam int ZS = 4;
  localparam int OS = 12;
  localparam int GP = 30;
  localparam int CH = 3;

  logic        iCLK;
  logic        iRST_n;
  logic        iSTART;
  logic        iREPEAT;
  logic [15:0] iADDR;
  logic [7:0]  iCMD;
  logic        oIRDA;
  logic        oIR_CARRIER;
  logic        oBUSY;
  logic        oDONE;

  int chk = 0;
  int err = 0;

  ir_transmit #(
    .LEAD_MARK_CYC(LM), .LEAD_SPACE_CYC(LS), .REP_SPACE_CYC(RS),
    .BIT_MARK_CYC(BM), .ZERO_SPACE_CYC(ZS), .ONE_SPACE_CYC(OS),
    .GAP_CYC(GP), .CARRIER_HALF_CYC(CH)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iREPEAT(iREPEAT),
    .iADDR(iADDR), .iCMD(iCMD), .oIRDA(oIRDA), .oIR_CARRIER(oIR_CARRIER),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- behavioural model: {irda, carrier, busy, done} per cycle
  localparam logic [3:0] IDLE_V = 4'b1000;
  logic [3:0] q[$];
  logic [3:0] exp_v = IDLE_V;

  task automatic push_seg(input bit mark, input int len, input bit done_last);
    for (int k = 0; k < len; k++)
      q.push_back({~mark, mark && ((k / CH) % 2 == 0), 1'b1, done_last && (k == len - 1)});
  endtask

  task automatic build(input bit rep, input logic [31:0] f);
    push_seg(1'b1, LM, 1'b0);
    if (rep) begin
      push_seg(1'b0, RS, 1'b0);
    end else begin
      push_seg(1'b0, LS, 1'b0);
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, BM, 1'b0);
        push_seg(1'b0, f[i] ? OS : ZS, 1'b0);
      end
    end
    push_seg(1'b1, BM, 1'b0);
    push_seg(1'b0, GP, 1'b1);
  endtask

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      q.delete();
      exp_v = IDLE_V;
    end else begin
      if (q.size() == 0 && exp_v[1] == 1'b0 && iSTART)
        build(iREPEAT, {~iCMD, iCMD, iADDR});
      if (q.size() > 0) exp_v = q.pop_front();
      else              exp_v = IDLE_V;
    end
  end

  always @(negedge iCLK) begin
    chk++;
    if ({oIRDA, oIR_CARRIER, oBUSY, oDONE} !== exp_v) begin
      err++;
      $display("FAIL cycle_model t=%0t actual={irda,car,busy,done}=%b required=%b",
               $time, {oIRDA, oIR_CARRIER, oBUSY, oDONE}, exp_v);
    end
  end

  // ---------------- monitors
  logic        prev_irda = 1'b1;
  int          hi_run = 0, lo_run = 0, lead_len = 0, nbit = 32;
  logic [31:0] dec = '0;
  int          busy_run = 0, busy_len = 0, done_cnt = 0, car_hi = 0;

  always @(negedge iCLK) begin
    if (oIRDA !== prev_irda) begin
      if (oIRDA == 1'b0) begin
        if (hi_run == LS) nbit = 0;
        else if (nbit < 32) begin
          dec[nbit] = (hi_run > (ZS + OS) / 2);
          nbit++;
        end
        lo_run = 1;
      end else begin
        if (lo_run > BM) lead_len = lo_run;
        hi_run = 1;
      end
    end else if (oIRDA) hi_run++;
    else lo_run++;
    prev_irda = oIRDA;

    if (oBUSY) busy_run++;
    else begin
      if (busy_run > 0) busy_len = busy_run;
      busy_run = 0;
    end
    if (oDONE) done_cnt++;
    if (oIR_CARRIER) car_hi++;
  end

  // ---------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] c, input bit r);
    @(negedge iCLK);
    iADDR = a; iCMD = c; iREPEAT = r; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit spurious);
    int n;
    n = 0;
    forever begin
      @(negedge iCLK);
      if (oDONE) begin
        iSTART = 1'b0;
        break;
      end
      if (spurious && $urandom_range(0, 40) == 0) begin
        iSTART = 1'b1;
        iCMD = 8'($urandom);
        iREPEAT = 1'($urandom);
      end else begin
        iSTART = 1'b0;
      end
      n++;
      if (n >= budget) begin
        chk++; err++;
        iSTART = 1'b0;
        $display("FAIL wait_done timeout actual=no_done required=done_within_%0d", budget);
        break;
      end
    end
  endtask

  // ---------------- stimulus
  initial begin
    int d0, c0;
    logic [31:0] w;
    bit r;
    iRST_n = 1'b0; iSTART = 1'b0; iREPEAT = 1'b0; iADDR = '0; iCMD = '0;
    repeat (3) @(negedge iCLK);
    check("rst_irda", 32'(oIRDA), 32'd1);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_carrier", 32'(oIR_CARRIER), 32'd0);
    check("rst_done", 32'(oDONE), 32'd0);
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);

    // full frame, with a rejected start during bit 10
    d0 = done_cnt;
    send(16'h00FF, 8'h16, 1'b0);
    repeat (200) @(negedge iCLK);
    iCMD = 8'hAA; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_done(2000, 1'b0);
    @(negedge iCLK); #1;
    check("frame_word", dec, 32'hE91600FF);
    check("frame_bits", 32'(nbit), 32'd32);
    check("lead_mark_len", 32'(lead_len), 32'(LM));
    check("frame_busy_len", 32'(busy_len), 32'd478);
    check("frame_done_cnt", 32'(done_cnt - d0), 32'd1);
    repeat (100) @(negedge iCLK);
    #1;
    check("no_second_frame", 32'(done_cnt - d0), 32'd1);
    check("idle_after_frame", 32'(busy_run), 32'd0);

    // repeat code
    d0 = done_cnt; c0 = car_hi;
    send(16'h1111, 8'h22, 1'b1);
    wait_done(2000, 1'b0);
    @(negedge iCLK); #1;
    check("repeat_busy_len", 32'(busy_len), 32'd84);
    check("repeat_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("repeat_carrier_hi", 32'(car_hi - c0), 32'd24);
    check("repeat_lead_len", 32'(lead_len), 32'(LM));

    // reset during leader space, then a complete frame
    send(16'h00FF, 8'h16, 1'b0);
    repeat (45) @(negedge iCLK);
    #2 iRST_n = 1'b0;
    #1;
    check("midrst_irda", 32'(oIRDA), 32'd1);
    check("midrst_busy", 32'(oBUSY), 32'd0);
    check("midrst_carrier", 32'(oIR_CARRIER), 32'd0);
    repeat (2) @(negedge iCLK);
    iRST_n = 1'b1;
    d0 = done_cnt;
    send(16'h1234, 8'h5A, 1'b0);
    wait_done(2000, 1'b0);
    @(negedge iCLK); #1;
    check("postrst_word", dec, 32'hA55A1234);
    check("postrst_done_cnt", 32'(done_cnt - d0), 32'd1);

    // randomized requests, back-to-back starts and spurious busy starts
    for (int it = 0; it < 14; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge iCLK);
      w = $urandom;
      r = ($urandom_range(0, 3) == 0);
      d0 = done_cnt;
      send(w[15:0], w[23:16], r);
      wait_done(2000, 1'b1);
      #1;
      if (!r) check("rand_word", dec, {~w[23:16], w[23:16], w[15:0]});
      check("rand_done_cnt", 32'(done_cnt - d0), 32'd1);
    end

    repeat (5) @(negedge iCLK);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
